// File: rtl/nokia_lcd_receiver.sv
// nokia_lcd_receiver
// PCD8544 (Nokia 5110) controller model on the far end of the display bus.
// It oversamples the SPI pins with clk, assembles MSB-first bytes, decodes
// command bytes into controller state, and writes data bytes into a
// COLS*BANKS byte framebuffer using the controller's address auto-increment.
`timescale 1ns/1ps

module nokia_lcd_receiver #(
  parameter int COLS  = 84,
  parameter int BANKS = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       sce,
  input  logic       dc,
  input  logic       lcd_rst_n,
  input  logic [8:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc,
  output logic       frame_error,
  output logic [6:0] x_addr,
  output logic [2:0] y_addr,
  output logic       pd,
  output logic       v,
  output logic       h,
  output logic [1:0] disp_de,
  output logic [6:0] vop,
  output logic [1:0] tc,
  output logic [2:0] bias
);

  localparam int         FB_DEPTH = COLS * BANKS;
  localparam logic [6:0] X_LIM    = 7'(COLS);
  localparam logic [6:0] X_MAX    = 7'(COLS - 1);
  localparam logic [2:0] Y_LIM    = 3'(BANKS);
  localparam logic [2:0] Y_MAX    = 3'(BANKS - 1);
  localparam logic [8:0] COLS9    = 9'(COLS);
  localparam logic [8:0] DEPTH9   = 9'(FB_DEPTH);

  // Pin synchronizers (bit 1 is the synchronized value)
  logic [1:0] r_sclk_s;
  logic [1:0] r_mosi_s;
  logic [1:0] r_sce_s;
  logic [1:0] r_dc_s;
  logic [1:0] r_lrst_s;
  logic       r_sclk_d;

  logic       w_sclk_rise;
  logic       w_sce_hi;
  logic       w_mosi;
  logic       w_dc;
  logic       w_lrst;

  // Byte assembly (stage p0)
  logic [2:0] r_bit_cnt;
  logic [6:0] r_sr;
  logic [7:0] r_byte_p0;
  logic       r_dc_p0;
  logic       r_vld_p0;
  logic       r_err_p0;

  // Next address after a data write
  logic [6:0] w_x_inc;
  logic [2:0] w_y_inc;

  // Framebuffer
  logic [7:0] r_fb [FB_DEPTH];
  logic [8:0] w_fb_addr;
  logic       w_fb_we;

  // Two-flop synchronizers; sce idles high and lcd_rst_n comes out of reset asserted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sclk_s <= 2'b00;
      r_mosi_s <= 2'b00;
      r_sce_s  <= 2'b11;
      r_dc_s   <= 2'b00;
      r_lrst_s <= 2'b00;
      r_sclk_d <= 1'b0;
    end else begin
      r_sclk_s <= {r_sclk_s[0], sclk};
      r_mosi_s <= {r_mosi_s[0], mosi};
      r_sce_s  <= {r_sce_s[0], sce};
      r_dc_s   <= {r_dc_s[0], dc};
      r_lrst_s <= {r_lrst_s[0], lcd_rst_n};
      r_sclk_d <= r_sclk_s[1];
    end
  end

  assign w_sclk_rise = r_sclk_s[1] & ~r_sclk_d;
  assign w_sce_hi    = r_sce_s[1];
  assign w_mosi      = r_mosi_s[1];
  assign w_dc        = r_dc_s[1];
  assign w_lrst      = ~r_lrst_s[1];

  // ---- stage p0: shift bits in, flag completed bytes and aborted frames ----
  // Shift on sclk rising edges while selected; deselect mid-byte drops the partial byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bit_cnt <= 3'd0;
      r_sr      <= 7'd0;
      r_byte_p0 <= 8'd0;
      r_dc_p0   <= 1'b0;
      r_vld_p0  <= 1'b0;
      r_err_p0  <= 1'b0;
    end else if (w_lrst) begin
      r_bit_cnt <= 3'd0;
      r_sr      <= 7'd0;
      r_byte_p0 <= 8'd0;
      r_dc_p0   <= 1'b0;
      r_vld_p0  <= 1'b0;
      r_err_p0  <= 1'b0;
    end else begin
      r_vld_p0 <= 1'b0;
      r_err_p0 <= 1'b0;
      if (w_sce_hi) begin
        if (r_bit_cnt != 3'd0) begin
          r_err_p0 <= 1'b1;
        end
        r_bit_cnt <= 3'd0;
        r_sr      <= 7'd0;
      end else if (w_sclk_rise) begin
        if (r_bit_cnt == 3'd7) begin
          r_byte_p0 <= {r_sr, w_mosi};
          r_dc_p0   <= w_dc;
          r_vld_p0  <= 1'b1;
          r_bit_cnt <= 3'd0;
          r_sr      <= 7'd0;
        end else begin
          r_sr      <= {r_sr[5:0], w_mosi};
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
      end
    end
  end

  // Auto-increment: horizontal mode walks X then Y, vertical mode walks Y then X
  always_comb begin
    w_x_inc = x_addr;
    w_y_inc = y_addr;
    if (!v) begin
      if (x_addr == X_MAX) begin
        w_x_inc = 7'd0;
        w_y_inc = (y_addr == Y_MAX) ? 3'd0 : y_addr + 3'd1;
      end else begin
        w_x_inc = x_addr + 7'd1;
      end
    end else begin
      if (y_addr == Y_MAX) begin
        w_y_inc = 3'd0;
        w_x_inc = (x_addr == X_MAX) ? 7'd0 : x_addr + 7'd1;
      end else begin
        w_y_inc = y_addr + 3'd1;
      end
    end
  end

  // ---- stage p1: strobes, command decode, address update ----
  // Command bytes update controller state; data bytes advance the write address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
      byte_data   <= 8'd0;
      byte_dc     <= 1'b0;
      x_addr      <= 7'd0;
      y_addr      <= 3'd0;
      pd          <= 1'b1;
      v           <= 1'b0;
      h           <= 1'b0;
      disp_de     <= 2'd0;
      vop         <= 7'd0;
      tc          <= 2'd0;
      bias        <= 3'd0;
    end else if (w_lrst) begin
      byte_valid  <= 1'b0;
      frame_error <= 1'b0;
      byte_data   <= 8'd0;
      byte_dc     <= 1'b0;
      x_addr      <= 7'd0;
      y_addr      <= 3'd0;
      pd          <= 1'b1;
      v           <= 1'b0;
      h           <= 1'b0;
      disp_de     <= 2'd0;
      vop         <= 7'd0;
      tc          <= 2'd0;
      bias        <= 3'd0;
    end else begin
      byte_valid  <= r_vld_p0;
      frame_error <= r_err_p0;
      if (r_vld_p0) begin
        byte_data <= r_byte_p0;
        byte_dc   <= r_dc_p0;
        if (r_dc_p0) begin
          x_addr <= w_x_inc;
          y_addr <= w_y_inc;
        end else if (r_byte_p0 != 8'h00) begin
          // 0x00 is NOP; it matches none of the patterns below either
          if (r_byte_p0[7:3] == 5'b00100) begin
            {pd, v, h} <= r_byte_p0[2:0];
          end else if (!h) begin
            if (r_byte_p0[7:3] == 5'b00001 && !r_byte_p0[1]) begin
              disp_de <= {r_byte_p0[2], r_byte_p0[0]};
            end else if (r_byte_p0[7:3] == 5'b01000) begin
              if (r_byte_p0[2:0] < Y_LIM) begin
                y_addr <= r_byte_p0[2:0];
              end
            end else if (r_byte_p0[7]) begin
              if (r_byte_p0[6:0] < X_LIM) begin
                x_addr <= r_byte_p0[6:0];
              end
            end
          end else begin
            if (r_byte_p0[7:2] == 6'b000001) begin
              tc <= r_byte_p0[1:0];
            end else if (r_byte_p0[7:3] == 5'b00010) begin
              bias <= r_byte_p0[2:0];
            end else if (r_byte_p0[7]) begin
              vop <= r_byte_p0[6:0];
            end
          end
        end
      end
    end
  end

  // Linear address y*COLS+x; with constant COLS this reduces to shift-and-add
  assign w_fb_addr = ({6'd0, y_addr} * COLS9) + {2'd0, x_addr};
  assign w_fb_we   = r_vld_p0 & r_dc_p0 & ~w_lrst;

  // Framebuffer write port; contents survive both resets
  always_ff @(posedge clk) begin
    if (w_fb_we) begin
      r_fb[w_fb_addr] <= r_byte_p0;
    end
  end

  // Synchronous read port; a same-cycle write to the same address returns the old byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= 8'd0;
    end else if (rd_addr < DEPTH9) begin
      rd_data <= r_fb[rd_addr];
    end else begin
      rd_data <= 8'd0;
    end
  end

endmodule

// File: tb/tb_nokia_lcd_receiver.sv
// Bench for nokia_lcd_receiver: directed display-controller scenarios followed
// by randomized byte traffic, checked against a byte-level controller model.
`timescale 1ns/1ps

module tb_nokia_lcd_receiver;

  localparam int COLS  = 84;
  localparam int BANKS = 6;
  localparam int DEPTH = COLS * BANKS;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       sce = 1'b1;
  logic       dc = 1'b0;
  logic       lcd_rst_n = 1'b1;
  logic [8:0] rd_addr = 9'd0;
  logic [7:0] rd_data;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_dc;
  logic       frame_error;
  logic [6:0] x_addr;
  logic [2:0] y_addr;
  logic       pd, v, h;
  logic [1:0] disp_de;
  logic [6:0] vop;
  logic [1:0] tc;
  logic [2:0] bias;

  nokia_lcd_receiver #(.COLS(COLS), .BANKS(BANKS)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .sce(sce), .dc(dc),
    .lcd_rst_n(lcd_rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_dc(byte_dc),
    .frame_error(frame_error), .x_addr(x_addr), .y_addr(y_addr),
    .pd(pd), .v(v), .h(h), .disp_de(disp_de), .vop(vop), .tc(tc), .bias(bias)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Controller model state
  int m_x, m_y, m_pd, m_v, m_h, m_de, m_vop, m_tc, m_bias, m_bd, m_bdc;
  int mfb [DEPTH];
  bit mknown [DEPTH];
  int m_last = 0;
  logic [8:0] q [$];
  logic [8:0] e;
  int exp_ferr = 0;
  int obs_ferr = 0;
  bit skip = 1'b1;
  bit rd_fix = 1'b0;
  int exp_rd = 0;
  bit exp_rd_ok = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_x = 0; m_y = 0; m_pd = 1; m_v = 0; m_h = 0; m_de = 0;
    m_vop = 0; m_tc = 0; m_bias = 0; m_bd = 0; m_bdc = 0;
  endfunction

  function automatic void model_apply(input int d, input int b);
    int idx;
    m_bd = b;
    m_bdc = d;
    if (d != 0) begin
      idx = m_y * COLS + m_x;
      mfb[idx] = b;
      mknown[idx] = 1'b1;
      m_last = idx;
      if (m_v == 0) begin
        idx = (idx + 1) % DEPTH;
        m_x = idx % COLS;
        m_y = idx / COLS;
      end else begin
        idx = (m_x * BANKS + m_y + 1) % DEPTH;
        m_x = idx / BANKS;
        m_y = idx % BANKS;
      end
    end else if (b == 0) begin
      // NOP
    end else if (b / 8 == 4) begin
      m_pd = (b / 4) % 2;
      m_v  = (b / 2) % 2;
      m_h  = b % 2;
    end else if (m_h == 0) begin
      if (b / 8 == 1 && (b / 2) % 2 == 0) m_de = ((b / 4) % 2) * 2 + b % 2;
      else if (b / 8 == 8) begin
        if (b % 8 < BANKS) m_y = b % 8;
      end else if (b >= 128) begin
        if (b - 128 < COLS) m_x = b - 128;
      end
    end else begin
      if (b / 4 == 1) m_tc = b % 4;
      else if (b / 8 == 2) m_bias = b % 8;
      else if (b >= 128) m_vop = b - 128;
    end
  endfunction

  // Per-cycle comparison against the model
  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      #1;
      if (skip) begin
        model_reset();
        q.delete();
        exp_rd_ok = 1'b0;
      end else begin
        if (exp_rd_ok) chk("rd_data", int'(rd_data), exp_rd);
        if (frame_error) obs_ferr++;
        if (byte_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_byte_valid", 1, 0);
          end else begin
            e = q.pop_front();
            model_apply(int'(e[8]), int'(e[7:0]));
          end
        end
        chk("byte_data", int'(byte_data), m_bd);
        chk("byte_dc", int'(byte_dc), m_bdc);
        chk("x_addr", int'(x_addr), m_x);
        chk("y_addr", int'(y_addr), m_y);
        chk("pd", int'(pd), m_pd);
        chk("v", int'(v), m_v);
        chk("h", int'(h), m_h);
        chk("disp_de", int'(disp_de), m_de);
        chk("vop", int'(vop), m_vop);
        chk("tc", int'(tc), m_tc);
        chk("bias", int'(bias), m_bias);
        if (int'(rd_addr) >= DEPTH) begin
          exp_rd = 0;
          exp_rd_ok = 1'b1;
        end else begin
          exp_rd = mfb[rd_addr];
          exp_rd_ok = mknown[rd_addr];
        end
      end
    end
  end

  // Random read address, biased toward the most recently written location
  initial begin
    forever begin
      @(negedge clk);
      if (!rd_fix) begin
        if ($urandom_range(0, 1) == 1) rd_addr = 9'(m_last);
        else rd_addr = 9'($urandom_range(0, 511));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send_bits(input logic [7:0] b, input logic d, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      mosi = b[7-i];
      dc = d;
      repeat (3) @(negedge clk);
      sclk = 1'b1;
      if (i == 7) q.push_back({d, b});
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic cmd(input logic [7:0] b);
    send_bits(b, 1'b0, 8);
  endtask

  task automatic data(input logic [7:0] b);
    send_bits(b, 1'b1, 8);
  endtask

  task automatic deselect();
    @(negedge clk);
    sce = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    #2;
    chk(name, q.size(), 0);
  endtask

  task automatic rd_check(input string name, input int addr, input int exp);
    rd_fix = 1'b1;
    @(negedge clk);
    rd_addr = 9'(addr);
    @(negedge clk);
    #2;
    chk(name, int'(rd_data), exp);
    rd_fix = 1'b0;
  endtask

  initial begin
    logic [7:0] rb;
    logic       rd;
    int         r;

    repeat (3) @(negedge clk);
    #2;
    chk("rst_pd", int'(pd), 1);
    chk("rst_x", int'(x_addr), 0);
    chk("rst_vop", int'(vop), 0);
    chk("rst_byte_valid", int'(byte_valid), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    skip = 1'b0;

    // Power-up sequence
    sce = 1'b0;
    cmd(8'h21);
    wait_drain("drain_21");
    chk("pwr_h1", int'(h), 1);
    cmd(8'h90);
    cmd(8'h20);
    cmd(8'h0C);
    deselect();
    wait_drain("drain_pwr");
    chk("pwr_h", int'(h), 0);
    chk("pwr_vop", int'(vop), 16);
    chk("pwr_pd", int'(pd), 0);
    chk("pwr_v", int'(v), 0);
    chk("pwr_de", int'(disp_de), 2);

    // Horizontal wrap
    sce = 1'b0;
    cmd(8'hD3);
    cmd(8'h45);
    data(8'hAA);
    data(8'h55);
    deselect();
    wait_drain("drain_hwrap");
    chk("hwrap_x", int'(x_addr), 1);
    chk("hwrap_y", int'(y_addr), 0);
    rd_check("fb503", 503, 8'hAA);
    rd_check("fb0", 0, 8'h55);

    // Vertical addressing
    sce = 1'b0;
    cmd(8'h22);
    cmd(8'h8A);
    cmd(8'h44);
    data(8'h01);
    data(8'h02);
    data(8'h03);
    deselect();
    wait_drain("drain_vert");
    chk("vert_x", int'(x_addr), 11);
    chk("vert_y", int'(y_addr), 1);
    rd_check("fb346", 346, 8'h01);
    rd_check("fb430", 430, 8'h02);
    rd_check("fb11", 11, 8'h03);

    // Out-of-range addresses are ignored
    sce = 1'b0;
    cmd(8'h20);
    cmd(8'h85);
    cmd(8'h42);
    cmd(8'hD4);
    cmd(8'h46);
    deselect();
    wait_drain("drain_illegal");
    chk("illegal_x", int'(x_addr), 5);
    chk("illegal_y", int'(y_addr), 2);

    // Aborted byte
    sce = 1'b0;
    send_bits(8'hB7, 1'b0, 5);
    deselect();
    exp_ferr++;
    repeat (8) @(negedge clk);
    #2;
    chk("abort_ferr_cnt", obs_ferr, 1);
    chk("abort_queue", q.size(), 0);
    chk("abort_x", int'(x_addr), 5);
    sce = 1'b0;
    cmd(8'h0D);
    deselect();
    wait_drain("drain_abort");
    chk("abort_de", int'(disp_de), 3);

    // Display reset pin preserves framebuffer
    sce = 1'b0;
    cmd(8'h90);
    cmd(8'h41);
    data(8'h7E);
    deselect();
    wait_drain("drain_fb100");
    rd_check("fb100_pre", 100, 8'h7E);
    @(negedge clk);
    skip = 1'b1;
    lcd_rst_n = 1'b0;
    repeat (6) @(negedge clk);
    lcd_rst_n = 1'b1;
    repeat (5) @(negedge clk);
    skip = 1'b0;
    #2;
    chk("lrst_pd", int'(pd), 1);
    chk("lrst_x", int'(x_addr), 0);
    chk("lrst_y", int'(y_addr), 0);
    chk("lrst_vop", int'(vop), 0);
    rd_check("fb100_post", 100, 8'h7E);

    // Hard reset in the middle of a byte
    @(negedge clk);
    skip = 1'b1;
    sce = 1'b0;
    send_bits(8'hC3, 1'b0, 3);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    skip = 1'b0;
    cmd(8'h0C);
    deselect();
    wait_drain("drain_midrst");
    chk("midrst_de", int'(disp_de), 2);

    // Randomized traffic
    sce = 1'b0;
    for (int n = 0; n < 160; n++) begin
      r = $urandom_range(0, 99);
      rd = 1'($urandom_range(0, 1));
      rb = 8'($urandom_range(0, 255));
      if (!rd && $urandom_range(0, 3) == 0) rb = 8'h20 | 8'($urandom_range(0, 7));
      if (r < 8) begin
        send_bits(rb, rd, $urandom_range(1, 7));
        deselect();
        exp_ferr++;
        repeat ($urandom_range(3, 6)) @(negedge clk);
        sce = 1'b0;
      end else begin
        if (r < 20) begin
          deselect();
          repeat ($urandom_range(3, 5)) @(negedge clk);
          sce = 1'b0;
        end
        send_bits(rb, rd, 8);
      end
    end
    deselect();
    wait_drain("drain_random");
    repeat (4) @(negedge clk);
    #2;
    chk("ferr_total", obs_ferr, exp_ferr);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
